// File: rtl/icache_assoc.sv
// icache_assoc - N-way set-associative instruction cache with line refill.
//
// Serves hits one cycle after acceptance. On a miss it requests the whole
// line from memory, captures the words in ascending order into the chosen
// victim way, installs the tag and returns the requested word. Replacement
// picks the lowest-index invalid way first, otherwise the per-set
// round-robin pointer. flush_in invalidates every line in a single cycle.
//
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit_count_out and
// miss_count_out (accepted hits / misses, cleared only by reset).
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global enable, freezes all state when low
//   flush_in                  invalidate all lines
//   req_valid_in/addr_in      fetch request, req_ready_out = accepted
//   resp_valid_out/instr_out  one-cycle instruction response
//   mem_req_valid_out/addr_out, mem_req_ready_in   line refill request
//   mem_resp_valid_in/data_in                      refill words
module icache_assoc #(
  parameter int WAYS          = 2,
  parameter int SET_BITS      = 6,
  parameter int WORD_OFF_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        req_valid_in,
  input  logic [31:0] req_addr_in,
  output logic        req_ready_out,
  output logic        resp_valid_out,
  output logic [31:0] resp_instr_out,
  output logic        mem_req_valid_out,
  output logic [31:0] mem_req_addr_out,
  input  logic        mem_req_ready_in,
  input  logic        mem_resp_valid_in,
  input  logic [31:0] mem_resp_data_in
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_OFF_BITS;
  localparam int TAG_W = 30 - SET_BITS - WORD_OFF_BITS;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LSB_I = WORD_OFF_BITS + 2;
  localparam int LSB_T = SET_BITS + WORD_OFF_BITS + 2;

  typedef enum logic [1:0] {S_IDLE, S_MISS_REQ, S_REFILL, S_RESP} state_e;

  // Request address fields
  logic [WORD_OFF_BITS-1:0] req_off;
  logic [SET_BITS-1:0]      req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [1:0]               unused_addr_bits;
  assign req_off          = req_addr_in[LSB_I-1:2];
  assign req_idx          = req_addr_in[LSB_T-1:LSB_I];
  assign req_tag          = req_addr_in[31:LSB_T];
  assign unused_addr_bits = req_addr_in[1:0];

  // Control state
  state_e                   state_q, state_d;
  logic [WORD_OFF_BITS-1:0] off_q, off_d;
  logic [SET_BITS-1:0]      idx_q, idx_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [WORD_OFF_BITS-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]         victim_q, victim_d;
  logic                     flushed_q, flushed_d;
  logic [31:0]              fill_word_q, fill_word_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [31:0]              resp_instr_q, resp_instr_d;
  logic                     mem_req_valid_q, mem_req_valid_d;
  logic [31:0]              mem_req_addr_q, mem_req_addr_d;

  // Per-set bookkeeping (registers, reset/flush cleared)
  logic [WAYS-1:0]  valid_q [SETS];
  logic [PTR_W-1:0] ptr_q   [SETS];

  logic [WAYS-1:0] way_hit;
  logic [31:0]     way_rd [WAYS];
  logic [31:0]     hit_word;
  logic            hit;
  logic            accept;
  logic            data_we;
  logic            fill_done;
  logic            install;
  logic [PTR_W-1:0] victim_sel;

  assign accept    = (state_q == S_IDLE) && rdy_in && !flush_in && req_valid_in;
  assign data_we   = (state_q == S_REFILL) && rdy_in && mem_resp_valid_in;
  assign fill_done = data_we && (cnt_q == {WORD_OFF_BITS{1'b1}});
  // A flush seen at any point of the refill (including its last cycle)
  // leaves the freshly written line invalid.
  assign install   = fill_done && !flushed_q && !flush_in;

  // Per-way tag/data storage and hit compare
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*WORDS];

    always_ff @(posedge clk_in) begin
      if (data_we && (victim_q == PTR_W'(gi))) begin
        data_mem[{idx_q, cnt_q}] <= mem_resp_data_in;
      end
      if (fill_done && (victim_q == PTR_W'(gi))) begin
        tag_mem[idx_q] <= tag_q;
      end
    end

    assign way_hit[gi] = valid_q[req_idx][gi] && (tag_mem[req_idx] == req_tag);
    assign way_rd[gi]  = data_mem[{req_idx, req_off}];
  end

  assign hit = |way_hit;

  // At most one way hits, so an AND-OR mux is sufficient.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_word = hit_word | ({32{way_hit[w]}} & way_rd[w]);
    end
  end

  // Lowest-index invalid way wins, else the round-robin pointer.
  always_comb begin
    victim_sel = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_sel = PTR_W'(w);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    idx_d           = idx_q;
    tag_d           = tag_q;
    cnt_d           = cnt_q;
    victim_d        = victim_q;
    flushed_d       = flushed_q;
    fill_word_d     = fill_word_q;
    resp_valid_d    = resp_valid_q;
    resp_instr_d    = resp_instr_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    if (rdy_in) begin
      resp_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (hit) begin
              resp_valid_d = 1'b1;
              resp_instr_d = hit_word;
            end else begin
              off_d           = req_off;
              idx_d           = req_idx;
              tag_d           = req_tag;
              victim_d        = victim_sel;
              flushed_d       = 1'b0;
              mem_req_valid_d = 1'b1;
              mem_req_addr_d  = {req_addr_in[31:LSB_I], {LSB_I{1'b0}}};
              state_d         = S_MISS_REQ;
            end
          end
        end
        S_MISS_REQ: begin
          if (flush_in) flushed_d = 1'b1;
          if (mem_req_ready_in) begin
            mem_req_valid_d = 1'b0;
            cnt_d           = '0;
            state_d         = S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_in) flushed_d = 1'b1;
          if (mem_resp_valid_in) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == off_q) fill_word_d = mem_resp_data_in;
            if (cnt_q == {WORD_OFF_BITS{1'b1}}) begin
              // The requested word may be arriving right now.
              resp_valid_d = 1'b1;
              resp_instr_d = (cnt_q == off_q) ? mem_resp_data_in : fill_word_q;
              state_d      = S_RESP;
            end
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= S_IDLE;
      off_q           <= '0;
      idx_q           <= '0;
      tag_q           <= '0;
      cnt_q           <= '0;
      victim_q        <= '0;
      flushed_q       <= 1'b0;
      fill_word_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_instr_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      idx_q           <= idx_d;
      tag_q           <= tag_d;
      cnt_q           <= cnt_d;
      victim_q        <= victim_d;
      flushed_q       <= flushed_d;
      fill_word_q     <= fill_word_d;
      resp_valid_q    <= resp_valid_d;
      resp_instr_q    <= resp_instr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  // Valid bits and victim pointers; flush has priority over installation.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          ptr_q[s]   <= '0;
        end
      end else if (install) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        if (victim_q == ptr_q[idx_q]) begin
          ptr_q[idx_q] <= (ptr_q[idx_q] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[idx_q] + 1'b1;
        end
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;
`endif

  // Ready is forced low while reset is held.
  assign req_ready_out     = rst_n_in && (state_q == S_IDLE) && rdy_in && !flush_in;
  assign resp_valid_out    = resp_valid_q;
  assign resp_instr_out    = resp_instr_q;
  assign mem_req_valid_out = mem_req_valid_q;
  assign mem_req_addr_out  = mem_req_addr_q;

endmodule
